// File: rtl/adder_pkg.sv
// Shared constants and helpers for the registered ripple-carry adder.
package adder_pkg;

  localparam int unsigned ADDER_DEFAULT_WIDTH = 9;

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic signed_overflow(input logic a_sign,
                                           input logic b_sign,
                                           input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

// File: rtl/adder_unit_full_adder_cell.sv
// Single-bit full adder; one link of the ripple-carry chain.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/adder_unit.sv
// Registered N-bit adder: ripple-carry datapath with registered sum, carry and signed-overflow flags.
module adder_unit
  import adder_pkg::*;
#(
  parameter int unsigned N = ADDER_DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic         out_valid,
  output logic [N-1:0] sum,
  output logic         carry_out,
  output logic         overflow
);

  logic [N:0]   carry;
  logic [N-1:0] sum_next;
  logic         overflow_next;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_chain
    full_adder_cell u_cell (
      .a    (input1[i]),
      .b    (input2[i]),
      .cin  (carry[i]),
      .s    (sum_next[i]),
      .cout (carry[i+1])
    );
  end

  assign overflow_next = signed_overflow(input1[N-1], input2[N-1], sum_next[N-1]);

  // Result registers hold across idle cycles; only the valid flag tracks in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= sum_next;
        carry_out <= carry[N];
        overflow  <= overflow_next;
      end
    end
  end

endmodule

// File: tb/tb_adder_unit.sv
// Directed and random checks of adder_unit; observed word is {out_valid, carry_out, overflow, sum}.
module tb_adder_unit;
  import adder_pkg::*;

  localparam int unsigned N = ADDER_DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [N-1:0] input1 = '0;
  logic [N-1:0] input2 = '0;
  logic         out_valid;
  logic [N-1:0] sum;
  logic         carry_out;
  logic         overflow;

  logic [N+2:0] obs;
  int           n_checks = 0;
  int           n_fail = 0;

  assign obs = {out_valid, carry_out, overflow, sum};

  always #5 clk = ~clk;

  adder_unit #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .input1    (input1),
    .input2    (input2),
    .out_valid (out_valid),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic drive_cycle(input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
    in_valid = v;
    input1   = a;
    input2   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: got %h expected %h", obs, 12'h000);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(1'b1, 9'h1FF, 9'h1FF);
    n_checks++;
    if (obs !== {1'b1, 1'b1, 1'b0, 9'h1FE}) begin
      n_fail++;
      $display("FAIL reset_preload: got %h expected %h", obs, {1'b1, 1'b1, 1'b0, 9'h1FE});
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", obs, 12'h000);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 9'h0AA, 9'h055);
      n_checks++;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs, 12'h000);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(1'b0, 9'h0AA, 9'h055);
    n_checks++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h expected %h", obs, 12'h000);
    end
    drive_cycle(1'b1, 9'h0AA, 9'h055);
    n_checks++;
    if (obs !== {1'b1, 1'b0, 1'b0, 9'h0FF}) begin
      n_fail++;
      $display("FAIL reset_first_result: got %h expected %h", obs, {1'b1, 1'b0, 1'b0, 9'h0FF});
    end
  endtask

  task automatic test_vectors();
    logic [N-1:0] va [8];
    logic [N-1:0] vb [8];
    logic [N+2:0] ve [8];
    va[0] = 9'h000; vb[0] = 9'h1FC; ve[0] = {1'b1, 1'b0, 1'b0, 9'h1FC};
    va[1] = 9'h1F0; vb[1] = 9'h1FF; ve[1] = {1'b1, 1'b1, 1'b0, 9'h1EF};
    va[2] = 9'h1FF; vb[2] = 9'h03F; ve[2] = {1'b1, 1'b1, 1'b0, 9'h03E};
    va[3] = 9'h1FF; vb[3] = 9'h1FF; ve[3] = {1'b1, 1'b1, 1'b0, 9'h1FE};
    va[4] = 9'h0FF; vb[4] = 9'h001; ve[4] = {1'b1, 1'b0, 1'b1, 9'h100};
    va[5] = 9'h100; vb[5] = 9'h100; ve[5] = {1'b1, 1'b1, 1'b1, 9'h000};
    va[6] = 9'h001; vb[6] = 9'h000; ve[6] = {1'b1, 1'b0, 1'b0, 9'h001};
    va[7] = 9'h000; vb[7] = 9'h000; ve[7] = {1'b1, 1'b0, 1'b0, 9'h000};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, va[i], vb[i]);
      n_checks++;
      if (obs !== ve[i]) begin
        n_fail++;
        $display("FAIL vector[%0d] %h+%h: got %h expected %h", i, va[i], vb[i], obs, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2*N-1:0] pat;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N:0]     full;
    logic [N+2:0]   exp;
    exp = '0;
    for (int k = 0; k < 27; k++) begin
      if (k < 20) begin
        pat  = (k < 18) ? (18'd1 << k) : ~(18'd1 << (k - 18));
        a    = pat[N-1:0];
        b    = pat[2*N-1:N];
        full = {1'b0, a} + {1'b0, b};
        exp  = {1'b1, full[N], signed_overflow(a[N-1], b[N-1], full[N-1]), full[N-1:0]};
        drive_cycle(1'b1, a, b);
      end else begin
        exp[N+2] = 1'b0;
        drive_cycle(1'b0, 9'h155, 9'h0AA);
      end
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL stream[%0d]: got %h expected %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         v;
    logic [N:0]   full;
    logic [N+2:0] exp;
    int           errs;
    exp  = obs;
    errs = 0;
    for (int i = 0; i < 10000; i++) begin
      v = ($urandom_range(0, 7) != 0);
      a = N'($urandom);
      b = N'($urandom);
      full = {1'b0, a} + {1'b0, b};
      if (v)
        exp = {1'b1, full[N], signed_overflow(a[N-1], b[N-1], full[N-1]), full[N-1:0]};
      else
        exp[N+2] = 1'b0;
      drive_cycle(v, a, b);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d] v=%b %h+%h: got %h expected %h", i, v, a, b, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
